// File: rtl/aes_dec_pkg.sv
// Shared types for the AES-128 inverse-cipher controller: FSM states, state_sel codes
// and the per-state output decode.
package aes_dec_pkg;

  typedef enum logic [2:0] {IDLE, KEXP, ARK, INV, FINAL, DONE} state_t;

  localparam logic [1:0] SEL_ARK   = 2'b00;
  localparam logic [1:0] SEL_FINAL = 2'b01;
  localparam logic [1:0] SEL_ROUND = 2'b10;

  typedef struct packed {
    logic       key_gate;
    logic       state_gate;
    logic       key_src;
    logic       key_dir;
    logic [1:0] state_sel;
    logic [3:0] round;
  } ctl_t;

  // idx is the forward step k in KEXP and the target key index r in INV.
  function automatic ctl_t decode(state_t st, logic [3:0] idx, logic [3:0] nr);
    ctl_t c;
    c = '0;
    case (st)
      KEXP: begin
        c.key_gate = 1'b1;
        c.key_src  = (idx != 4'd1);
        c.key_dir  = 1'b0;
        c.round    = idx;
      end
      ARK: begin
        c.state_gate = 1'b1;
        c.state_sel  = SEL_ARK;
        c.round      = nr;
      end
      INV: begin
        c.key_gate   = 1'b1;
        c.state_gate = 1'b1;
        c.key_src    = 1'b1;
        c.key_dir    = 1'b1;
        c.state_sel  = SEL_ROUND;
        c.round      = idx + 4'd1;
      end
      FINAL: begin
        c.key_gate   = 1'b1;
        c.state_gate = 1'b1;
        c.key_src    = 1'b1;
        c.key_dir    = 1'b1;
        c.state_sel  = SEL_FINAL;
        c.round      = 4'd1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_dec_controller_timer.sv
// Per-step cycle timer: counts 0..CPS-1 and flags the last cycle of each step.
// step is registered from the next count so it lines up with the counter value.
module aes_step_timer #(
  parameter int CPS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic step
);

  localparam int CW = (CPS > 1) ? $clog2(CPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (clear || (cnt == LAST)) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      step <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      step <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/aes_dec_controller.sv
// AES-128 inverse-cipher sequencer: forward key expansion to key NR, then inverse rounds
// with a backwards key walk. Optional busy output under AES_DEC_BUSY_EN.
module aes_dec_controller
  import aes_dec_pkg::*;
#(
  parameter int NR  = 10,
  parameter int CPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  output logic       key_en,
  output logic       key_src,
  output logic       key_dir,
  output logic       state_en,
  output logic [1:0] state_sel,
  output logic [3:0] round,
  output logic       done
`ifdef AES_DEC_BUSY_EN
  ,
  output logic       busy
`endif
);

  localparam logic [3:0] NR4 = 4'(NR);

  state_t     st;
  state_t     st_nxt;
  logic [3:0] idx;
  logic [3:0] idx_nxt;
  logic       step;
  logic       clear;
  ctl_t       ctl;

  // Holding the timer cleared while parked means every run begins at count 0.
  assign clear = (st == IDLE) || (st == DONE);

  aes_step_timer #(.CPS(CPS)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step)
  );

  always_comb begin
    st_nxt  = st;
    idx_nxt = idx;
    case (st)
      IDLE, DONE: begin
        if (load) begin
          st_nxt  = KEXP;
          idx_nxt = 4'd1;
        end
      end
      KEXP: begin
        if (step) begin
          if (idx == NR4) begin
            st_nxt  = ARK;
            idx_nxt = NR4;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      ARK: begin
        if (step) begin
          if (NR4 > 4'd1) begin
            st_nxt  = INV;
            idx_nxt = NR4 - 4'd1;
          end else begin
            st_nxt  = FINAL;
            idx_nxt = 4'd0;
          end
        end
      end
      INV: begin
        if (step) begin
          if (idx == 4'd1) begin
            st_nxt  = FINAL;
            idx_nxt = 4'd0;
          end else begin
            idx_nxt = idx - 4'd1;
          end
        end
      end
      FINAL: begin
        if (step) begin
          st_nxt  = DONE;
          idx_nxt = 4'd0;
        end
      end
      default: begin
        st_nxt  = IDLE;
        idx_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st   <= IDLE;
      idx  <= 4'd0;
      ctl  <= '0;
      done <= 1'b0;
`ifdef AES_DEC_BUSY_EN
      busy <= 1'b0;
`endif
    end else begin
      st   <= st_nxt;
      idx  <= idx_nxt;
      ctl  <= decode(st_nxt, idx_nxt, NR4);
      done <= (st_nxt == DONE);
`ifdef AES_DEC_BUSY_EN
      busy <= (st_nxt == KEXP) || (st_nxt == ARK) || (st_nxt == INV) || (st_nxt == FINAL);
`endif
    end
  end

  // Strobes fire only in a step's last cycle; both terms are cleared by reset.
  assign key_en    = ctl.key_gate & step;
  assign state_en  = ctl.state_gate & step;
  assign key_src   = ctl.key_src;
  assign key_dir   = ctl.key_dir;
  assign state_sel = ctl.state_sel;
  assign round     = ctl.round;

endmodule

// File: tb/tb_aes_dec_controller.sv
// Scoreboard bench for aes_dec_controller: default instance checked step by step,
// a CPS=1 instance checked by strobe and latency counts.
module tb_aes_dec_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load;
  logic       key_en, key_src, key_dir, state_en, done;
  logic [1:0] state_sel;
  logic [3:0] round;

  logic       reset1, load1;
  logic       key_en1, key_src1, key_dir1, state_en1, done1;
  logic [1:0] state_sel1;
  logic [3:0] round1;
`ifdef AES_DEC_BUSY_EN
  logic       busy, busy1;
`endif

  aes_dec_controller dut (
    .clk(clk), .reset(reset), .load(load),
    .key_en(key_en), .key_src(key_src), .key_dir(key_dir),
    .state_en(state_en), .state_sel(state_sel), .round(round), .done(done)
`ifdef AES_DEC_BUSY_EN
    , .busy(busy)
`endif
  );

  aes_dec_controller #(.NR(10), .CPS(1)) dut1 (
    .clk(clk), .reset(reset1), .load(load1),
    .key_en(key_en1), .key_src(key_src1), .key_dir(key_dir1),
    .state_en(state_en1), .state_sel(state_sel1), .round(round1), .done(done1)
`ifdef AES_DEC_BUSY_EN
    , .busy(busy1)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit       is_done;
    bit       ke, se, ks, kd;
    bit [1:0] sel;
    bit [3:0] rnd;
    int       at;
  } exp_t;
  exp_t q[$];

  task automatic push_step(int at, bit ke, bit se, bit ks, bit kd, bit [1:0] sel, bit [3:0] rnd);
    exp_t e;
    e.is_done = 1'b0; e.ke = ke; e.se = se; e.ks = ks; e.kd = kd;
    e.sel = sel; e.rnd = rnd; e.at = at;
    q.push_back(e);
  endtask

  // Default NR=10, CPS=2 schedule for a load sampled at edge l.
  task automatic push_run(int l);
    exp_t e;
    int s;
    s = 0;
    for (int k = 1; k <= 10; k++) begin
      s++;
      push_step(l + s*2 - 1, 1'b1, 1'b0, (k != 1), 1'b0, 2'b00, 4'(k));
    end
    s++;
    push_step(l + s*2 - 1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd10);
    for (int r = 9; r >= 1; r--) begin
      s++;
      push_step(l + s*2 - 1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 4'(r + 1));
    end
    s++;
    push_step(l + s*2 - 1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 4'd1);
    e.is_done = 1'b1; e.ke = 0; e.se = 0; e.ks = 0; e.kd = 0; e.sel = 0; e.rnd = 0;
    e.at = l + 42;
    q.push_back(e);
  endtask

  exp_t m;
  bit   done_q = 1'b0;
  bit   ok;

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].at < cyc) begin
      m = q.pop_front();
      total++; bad++;
      $display("FAIL missed_event at=%0d now=%0d is_done=%0d", m.at, cyc, m.is_done);
    end else if (q.size() > 0 && q[0].at == cyc) begin
      m = q.pop_front();
      total++;
      if (m.is_done) begin
        if (!(done && !done_q)) begin
          bad++;
          $display("FAIL done_rise cyc=%0d got done=%0d prev=%0d want rising", cyc, done, done_q);
        end
      end else begin
        ok = (key_en == m.ke) && (state_en == m.se) && (state_sel == m.sel) && (round == m.rnd) &&
             (!m.ke || ((key_src == m.ks) && (key_dir == m.kd)));
        if (!ok) begin
          bad++;
          $display("FAIL step cyc=%0d got ke=%0d se=%0d ks=%0d kd=%0d sel=%0d rnd=%0d want ke=%0d se=%0d ks=%0d kd=%0d sel=%0d rnd=%0d",
                   cyc, key_en, state_en, key_src, key_dir, state_sel, round,
                   m.ke, m.se, m.ks, m.kd, m.sel, m.rnd);
        end
      end
    end else begin
      if (key_en || state_en) begin
        total++; bad++;
        $display("FAIL unexpected_strobe cyc=%0d got ke=%0d se=%0d want none", cyc, key_en, state_en);
      end
      if (done && !done_q) begin
        total++; bad++;
        $display("FAIL unexpected_done cyc=%0d got done rising want none", cyc);
      end
    end
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  int l;
  int n, kc, sc, stc, bc;

  initial begin
    reset = 1'b1; load = 1'b0; reset1 = 1'b1; load1 = 1'b0;
    repeat (2) tick();
    check("reset_outputs", {key_en, state_en, key_src, key_dir, state_sel, round, done}, 0);
    reset = 1'b0; reset1 = 1'b0;
    repeat (10) tick();
    check("idle_outputs", {key_en, state_en, key_src, key_dir, state_sel, round, done}, 0);

    // Plain run
    load = 1'b1; l = cyc + 1; push_run(l);
    tick(); load = 1'b0;
    repeat (45) tick();
    check("done_held", done, 1);
    check("done_outputs_zero", {key_en, state_en, key_src, key_dir, state_sel, round}, 0);

    // Restart from DONE with a stray load mid-run
    load = 1'b1; l = cyc + 1; push_run(l);
    tick(); load = 1'b0;
    repeat (4) tick();
    load = 1'b1; tick(); load = 1'b0;
    repeat (45) tick();
    check("done_after_stray_load", done, 1);

    // Reset during INV r=4
    load = 1'b1; l = cyc + 1; push_run(l);
    tick(); load = 1'b0;
    repeat (32) tick();
    check("in_inv_r4_round", round, 5);
    q.delete();
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", {key_en, state_en, key_src, key_dir, state_sel, round, done}, 0);
    tick(); tick();
    reset = 1'b0;
    repeat (10) tick();
    load = 1'b1; l = cyc + 1; push_run(l);
    tick(); load = 1'b0;
    repeat (45) tick();
    check("done_after_reset_run", done, 1);

    // load held high straight through DONE
    load = 1'b1; l = cyc + 1; push_run(l); push_run(l + 43);
    tick();
    repeat (42) tick();
    check("hold_done_high", done, 1);
    tick();
    check("hold_done_cleared", done, 0);
    check("hold_kexp_round", round, 1);
    load = 1'b0;
    repeat (45) tick();
    check("hold_second_done", done, 1);

    // CPS=1 instance
    load1 = 1'b1; tick(); load1 = 1'b0;
    n = 0; kc = 0; sc = 0; stc = 0; bc = 0;
    for (int i = 0; i < 60; i++) begin
      if (done1) break;
      kc  += int'(key_en1);
      sc  += int'(state_en1);
      stc += int'(key_en1 | state_en1);
`ifdef AES_DEC_BUSY_EN
      bc  += int'(busy1);
`endif
      n++;
      tick();
    end
    check("cps1_latency", n, 21);
    check("cps1_key_strobes", kc, 20);
    check("cps1_state_strobes", sc, 11);
    check("cps1_strobe_cycles", stc, 21);
`ifdef AES_DEC_BUSY_EN
    check("cps1_busy_cycles", bc, 21);
    check("cps1_busy_low_at_done", busy1, 0);
`endif
    check("cps1_round_at_done", round1, 0);

    repeat (3) tick();
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
